// File: rtl/led_pulse_stretch.sv
// Stretches pulse_in rising edges into fixed ON/OFF LED intervals timed by a prescaled tick.
// Define PULSE_QUEUE_EN to queue events arriving while busy (up to 15); otherwise they are dropped.
module led_pulse_stretch #(
    parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
    parameter int unsigned TICK_FREQUENCY_HZ      = 1000,
    parameter int unsigned ON_TICKS               = 50,
    parameter int unsigned OFF_TICKS              = 50,
    parameter int unsigned CNTR_WIDTH             = 32,
    parameter int unsigned SIMULATE               = 0,
    parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pulse_in,
    output logic       led_out,
    output logic       busy,
    output logic       dropped,
    output logic [3:0] pending_cnt
);

    localparam logic [CNTR_WIDTH-1:0] TERM = (SIMULATE != 0)
        ? CNTR_WIDTH'(SIMULATE_FREQUENCY_CNT)
        : CNTR_WIDTH'(CLK_FREQUENCY_HZ / TICK_FREQUENCY_HZ - 1);
    localparam logic [7:0] ON_LAST  = 8'(ON_TICKS - 1);
    localparam logic [7:0] OFF_LAST = 8'(OFF_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t                state_q;
    logic                  pulse_q;
    logic                  led_q;
    logic                  busy_q;
    logic                  dropped_q;
    logic [CNTR_WIDTH-1:0] presc_q;
    logic [7:0]            ticks_q;
    logic [3:0]            pend_q;
    logic [3:0]            pend_d;
    logic                  drop_d;
    logic                  restart;
    logic                  evt;
    logic                  busy_evt;
    logic                  tick;
    logic                  on_done;
    logic                  off_done;

    assign evt      = pulse_in & ~pulse_q;
    assign busy_evt = evt && (state_q != S_IDLE);
    assign tick     = (state_q != S_IDLE) && (presc_q == TERM);
    assign on_done  = (state_q == S_ON)  && tick && (ticks_q == ON_LAST);
    assign off_done = (state_q == S_OFF) && tick && (ticks_q == OFF_LAST);

`ifdef PULSE_QUEUE_EN
    // An event landing on the final OFF tick is consumed directly (pending 0) or
    // balances the dequeue (pending > 0), so the count never strands in IDLE.
    always_comb begin
        pend_d  = pend_q;
        drop_d  = 1'b0;
        restart = off_done && ((pend_q != 4'd0) || evt);
        if (busy_evt && off_done) begin
            pend_d = pend_q;
        end else if (busy_evt) begin
            if (pend_q == 4'd15) begin
                drop_d = 1'b1;
            end else begin
                pend_d = pend_q + 4'd1;
            end
        end else if (off_done && (pend_q != 4'd0)) begin
            pend_d = pend_q - 4'd1;
        end
    end
`else
    always_comb begin
        pend_d  = '0;
        drop_d  = busy_evt;
        restart = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pulse_q   <= 1'b0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
            presc_q   <= '0;
            ticks_q   <= '0;
            pend_q    <= '0;
        end else begin
            pulse_q   <= pulse_in;
            pend_q    <= pend_d;
            dropped_q <= drop_d;
            case (state_q)
                S_IDLE: begin
                    presc_q <= '0;
                    ticks_q <= '0;
                    if (evt) begin
                        state_q <= S_ON;
                        led_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (on_done) begin
                        state_q <= S_OFF;
                        led_q   <= 1'b0;
                        presc_q <= '0;
                        ticks_q <= '0;
                    end else if (tick) begin
                        presc_q <= '0;
                        ticks_q <= ticks_q + 8'd1;
                    end else begin
                        presc_q <= presc_q + CNTR_WIDTH'(1);
                    end
                end
                S_OFF: begin
                    if (off_done) begin
                        presc_q <= '0;
                        ticks_q <= '0;
                        if (restart) begin
                            state_q <= S_ON;
                            led_q   <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (tick) begin
                        presc_q <= '0;
                        ticks_q <= ticks_q + 8'd1;
                    end else begin
                        presc_q <= presc_q + CNTR_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_out     = led_q;
    assign busy        = busy_q;
    assign dropped     = dropped_q;
    assign pending_cnt = pend_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed bench for led_pulse_stretch with 4-cycle ticks, ON/OFF of 2 ticks (8 cycles each).
// Queue-specific scenarios are built only when PULSE_QUEUE_EN is defined.
module tb_led_pulse_stretch;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pulse_in;
    logic       led_out;
    logic       busy;
    logic       dropped;
    logic [3:0] pending_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pulse_stretch #(
        .CLK_FREQUENCY_HZ      (100000000),
        .TICK_FREQUENCY_HZ     (1000),
        .ON_TICKS              (2),
        .OFF_TICKS             (2),
        .CNTR_WIDTH            (32),
        .SIMULATE              (1),
        .SIMULATE_FREQUENCY_CNT(3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pulse_in   (pulse_in),
        .led_out    (led_out),
        .busy       (busy),
        .dropped    (dropped),
        .pending_cnt(pending_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int highs;
    int rises;
    int drops;
    logic prev;

    initial begin
        reset_n  = 1'b0;
        pulse_in = 1'b0;
        step();
        step();
        chk("rst_led", 32'(led_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dropped", 32'(dropped), 0);
        chk("rst_pending", 32'(pending_cnt), 0);
        reset_n = 1'b1;
        step();
        step();
        chk("idle_led", 32'(led_out), 0);

        // single one-cycle pulse
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("single_on_led", 32'(led_out), 1);
            chk("single_on_busy", 32'(busy), 1);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            chk("single_off_led", 32'(led_out), 0);
            chk("single_off_busy", 32'(busy), 1);
            step();
        end
        chk("single_end_busy", 32'(busy), 0);
        chk("single_end_led", 32'(led_out), 0);

        // held high for 100 cycles: one event only
        highs = 0;
        rises = 0;
        prev  = 1'b0;
        pulse_in = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if (i == 100) pulse_in = 1'b0;
            step();
            if (led_out) highs++;
            if (led_out && !prev) rises++;
            prev = led_out;
        end
        chk("held_high_cycles", 32'(highs), 8);
        chk("held_intervals", 32'(rises), 1);
        chk("held_end_busy", 32'(busy), 0);

`ifndef PULSE_QUEUE_EN
        // edge during ON is dropped
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        step();
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        chk("drop_pulse", 32'(dropped), 1);
        chk("drop_pending", 32'(pending_cnt), 0);
        chk("drop_led", 32'(led_out), 1);
        highs = 0;
        rises = 0;
        drops = 0;
        prev  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (led_out) highs++;
            if (led_out && !prev) rises++;
            if (dropped) drops++;
            prev = led_out;
        end
        chk("drop_rest_high", 32'(highs), 5);
        chk("drop_no_new_interval", 32'(rises), 0);
        chk("drop_one_cycle", 32'(drops), 0);
        chk("drop_end_busy", 32'(busy), 0);
`else
        // three edges within the first ON
        highs = 0;
        rises = 0;
        drops = 0;
        prev  = 1'b1;
        pulse_in = 1'b1;
        step();
        for (int c = 2; c <= 60; c++) begin
            pulse_in = (c == 3) || (c == 5);
            step();
            if (c == 5) chk("q3_pending", 32'(pending_cnt), 2);
            if (c == 16) chk("q3_gap_low", 32'(led_out), 0);
            if (c == 17) begin
                chk("q3_second_on", 32'(led_out), 1);
                chk("q3_pending_dec", 32'(pending_cnt), 1);
            end
            if (c == 33) chk("q3_third_pending", 32'(pending_cnt), 0);
            if (led_out) highs++;
            if (led_out && !prev) rises++;
            if (dropped) drops++;
            prev = led_out;
        end
        chk("q3_high_cycles", 32'(highs), 23);
        chk("q3_new_intervals", 32'(rises), 2);
        chk("q3_no_drop", 32'(drops), 0);
        chk("q3_end_busy", 32'(busy), 0);

        // saturation at 15, coincident event+dequeue
        drops = 0;
        pulse_in = 1'b1;
        step();
        for (int c = 2; c <= 40; c++) begin
            pulse_in = (c % 2 == 1) && (c >= 3) && (c <= 37);
            step();
            if (dropped) drops++;
            if (c == 15) chk("sat_pending_c15", 32'(pending_cnt), 7);
            if (c == 17) chk("sat_coincident", 32'(pending_cnt), 7);
            if (c == 33) chk("sat_coincident2", 32'(pending_cnt), 14);
            if (c == 35) chk("sat_full", 32'(pending_cnt), 15);
            if (c == 37) begin
                chk("sat_drop", 32'(dropped), 1);
                chk("sat_hold", 32'(pending_cnt), 15);
            end
            if (c == 38) chk("sat_drop_one_cycle", 32'(dropped), 0);
        end
        pulse_in = 1'b0;
        chk("sat_drop_count", 32'(drops), 1);
        for (int i = 0; i < 400 && busy; i++) step();
        chk("sat_drain_busy", 32'(busy), 0);
        chk("sat_drain_pending", 32'(pending_cnt), 0);
`endif

        // reset during ON
        pulse_in = 1'b1;
        step();
        for (int c = 2; c <= 7; c++) begin
            pulse_in = (c == 3) || (c == 5) || (c == 7);
            step();
        end
        pulse_in = 1'b0;
        chk("mid_led", 32'(led_out), 1);
`ifdef PULSE_QUEUE_EN
        chk("mid_pending", 32'(pending_cnt), 3);
`else
        chk("mid_dropped", 32'(dropped), 1);
`endif
        reset_n = 1'b0;
        #1;
        chk("abort_led", 32'(led_out), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pending", 32'(pending_cnt), 0);
        chk("abort_dropped", 32'(dropped), 0);
        step();
        reset_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (led_out || busy) highs++;
        end
        chk("post_reset_quiet", 32'(highs), 0);
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        chk("post_reset_new_edge", 32'(led_out), 1);
        for (int i = 0; i < 30 && busy; i++) step();
        chk("post_reset_end_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
